stencil_stream_feeder: RTL and testbench

Responder for the accelerator's input-stencil pull interface. Each `*_read_en` / `*_read` port pair on a generated clockwork accelerator is a pull port: the accelerator raises `read_en` in the cycle it consumes a word, and that word must already be on `read`. This block is the other end of that port. It buffers words written by a host or DMA stream, presents the head word, and pops one word per `read_en`. It also counts a configured tile length and flags underruns. One instance sits in front of each input stencil port.

---
 rtl/stencil_feeder_pkg.sv | 20 ++
 rtl/stencil_stream_feeder_if.sv | 21 ++
 rtl/stencil_feeder_fifo.sv | 53 +++++
 rtl/stencil_stream_feeder.sv | 131 +++++++++++++
 tb/tb_stencil_stream_feeder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/stencil_feeder_pkg.sv
// Shared types and constants for the stencil stream feeder.
// The LFSR constants are only used when STENCIL_FEEDER_LFSR_EN is defined.
package stencil_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } feeder_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // x^16+x^14+x^13+x^11+1 as feedback taps of a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/stencil_stream_feeder_if.sv
// Host word stream plus accelerator pull port of one stencil feeder.
// master = environment (host and accelerator), slave = the feeder.
interface stencil_stream_feeder_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              read_en;
    logic [DATA_W-1:0] read;

    modport master (
        output in_valid, in_data, read_en,
        input  in_ready, read
    );

    modport slave (
        input  in_valid, in_data, read_en,
        output in_ready, read
    );
endinterface

// File: rtl/stencil_feeder_fifo.sv
// Power-of-two FIFO with synchronous clear, occupancy counter and registered head.
// Push when full and pop when empty are ignored.
module stencil_feeder_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; empty masks stale entries, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/stencil_stream_feeder.sv
// Pull-port responder: buffers host words, serves one word per read_en, counts a tile.
// rst_n is synchronous ACTIVE-HIGH. Optional STENCIL_FEEDER_LFSR_EN adds an internal LFSR source.
module stencil_stream_feeder
    import stencil_feeder_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    start,
    input  logic [CNT_W-1:0]        cfg_total,
`ifdef STENCIL_FEEDER_LFSR_EN
    input  logic                    lfsr_mode,
`endif
    stencil_stream_feeder_if.slave  bus,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun,
    output logic [CNT_W-1:0]        consumed
);
    feeder_state_t     state;
    feeder_state_t     state_next;
    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  accepted;
    logic [CNT_W-1:0]  consumed_q;
    logic              underrun_q;

    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic              start_ok;
    logic              clear_fifo;
    logic              room;
    logic              host_en;
    logic              host_push;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              in_ready;

    assign start_ok   = start && (state == IDLE || state == DONE);
    assign clear_fifo = rst_n || flush || start_ok;
    assign room       = !full && (accepted < total);
    assign in_ready   = (state == RUN) && room && host_en;
    assign host_push  = bus.in_valid && in_ready;
    assign pop        = bus.read_en && !empty && (state == RUN);

`ifdef STENCIL_FEEDER_LFSR_EN
    logic [15:0] lfsr;
    logic        lfsr_push;

    assign host_en   = !lfsr_mode;
    assign lfsr_push = lfsr_mode && (state == RUN) && room;
    assign push      = host_push || lfsr_push;
    assign push_data = lfsr_push ? DATA_W'(lfsr) : bus.in_data;

    always_ff @(posedge clk) begin
        if (rst_n || flush || start_ok) lfsr <= LFSR_SEED;
        else if (lfsr_push)             lfsr <= lfsr_next(lfsr);
    end
`else
    assign host_en   = 1'b1;
    assign push      = host_push;
    assign push_data = bus.in_data;
`endif

    stencil_feeder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clear (clear_fifo),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst_n || flush) state <= IDLE;
        else                state <= state_next;
    end

    // NOTE: defaults first in always_comb so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = (cfg_total == '0) ? DONE : RUN;
            RUN:        if (pop && (consumed_q + 1'b1 == total)) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            total      <= '0;
            accepted   <= '0;
            consumed_q <= '0;
            underrun_q <= 1'b0;
        end else if (flush) begin
            total      <= '0;
            accepted   <= '0;
            consumed_q <= '0;
        end else begin
            if (start_ok) begin
                total      <= cfg_total;
                accepted   <= '0;
                consumed_q <= '0;
            end else begin
                if (push) accepted   <= accepted + 1'b1;
                if (pop)  consumed_q <= consumed_q + 1'b1;
            end
            // an empty-FIFO read in the start cycle still counts as an underrun
            if (bus.read_en && empty) underrun_q <= 1'b1;
            else if (start_ok)        underrun_q <= 1'b0;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.read     = empty ? '0 : head;
    assign busy         = (state == RUN);
    assign done         = (state == DONE);
    assign underrun     = underrun_q;
    assign consumed     = consumed_q;

endmodule

// File: tb/tb_stencil_stream_feeder.sv
// Directed bench for stencil_stream_feeder: vector table plus hand sequences for fill, flush and LFSR.
// Inputs change on the falling edge; outputs are compared 1 ns after the rising edge.
module tb_stencil_stream_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        start;
    logic [31:0] cfg_total;
    logic        lfsr_mode;
    logic        busy;
    logic        done;
    logic        underrun;
    logic [31:0] consumed;

    int n_vec  = 0;
    int n_miss = 0;

    stencil_stream_feeder_if #(.DATA_W(16)) bus ();

    stencil_stream_feeder #(.DATA_W(16), .DEPTH(8), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .start     (start),
        .cfg_total (cfg_total),
`ifdef STENCIL_FEEDER_LFSR_EN
        .lfsr_mode (lfsr_mode),
`endif
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun),
        .consumed  (consumed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [31:0] cfg;
        logic        iv;
        logic [15:0] data;
        logic        re;
        logic [15:0] exp_read;
        logic        exp_ready;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_under;
        logic [31:0] exp_cons;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic st, logic [31:0] cfg, logic iv, logic [15:0] d, logic re,
                                logic [15:0] rd, logic rdy, logic bz, logic dn, logic un,
                                logic [31:0] cs);
        vec_t v;
        v.start = st; v.cfg = cfg; v.iv = iv; v.data = d; v.re = re;
        v.exp_read = rd; v.exp_ready = rdy; v.exp_busy = bz; v.exp_done = dn;
        v.exp_under = un; v.exp_cons = cs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare(input string tag, input logic [15:0] rd, input logic rdy,
                           input logic bz, input logic dn, input logic un, input logic [31:0] cs);
        n_vec++;
        check({tag, ".read"},     32'(bus.read),     32'(rd));
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
        check({tag, ".busy"},     32'(busy),         32'(bz));
        check({tag, ".done"},     32'(done),         32'(dn));
        check({tag, ".underrun"}, 32'(underrun),     32'(un));
        check({tag, ".consumed"}, consumed,          cs);
    endtask

    task automatic step(input logic st, input logic [31:0] cfg, input logic iv,
                        input logic [15:0] d, input logic re, input logic fl);
        @(negedge clk);
        start = st; cfg_total = cfg; bus.in_valid = iv; bus.in_data = d;
        bus.read_en = re; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; flush = 1'b0; cfg_total = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.read_en = 1'b0; lfsr_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // start, cfg, iv, data, re  ->  read, in_ready, busy, done, underrun, consumed
        tbl[0]  = mk(1, 4, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 16'h0011, 0, 16'h0011, 1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 16'h0022, 1, 16'h0022, 1, 1, 0, 0, 1);
        tbl[3]  = mk(0, 0, 1, 16'h0033, 1, 16'h0033, 1, 1, 0, 0, 2);
        tbl[4]  = mk(0, 0, 1, 16'h0044, 1, 16'h0044, 0, 1, 0, 0, 3);
        tbl[5]  = mk(0, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 1, 0, 4);
        tbl[6]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 4);
        tbl[7]  = mk(1, 3, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 16'h0000, 1, 16'h0000, 1, 1, 0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 1, 0);
        tbl[10] = mk(0, 0, 1, 16'h00A1, 0, 16'h00A1, 1, 1, 0, 1, 0);
        tbl[11] = mk(0, 0, 1, 16'h00A2, 0, 16'h00A1, 1, 1, 0, 1, 0);
        tbl[12] = mk(0, 0, 1, 16'h00A3, 0, 16'h00A1, 0, 1, 0, 1, 0);
        tbl[13] = mk(0, 0, 1, 16'h00A4, 0, 16'h00A1, 0, 1, 0, 1, 0);
        tbl[14] = mk(0, 0, 1, 16'h00A5, 0, 16'h00A1, 0, 1, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 16'h0000, 1, 16'h00A2, 0, 1, 0, 1, 1);
        tbl[16] = mk(0, 0, 0, 16'h0000, 1, 16'h00A3, 0, 1, 0, 1, 2);
        tbl[17] = mk(0, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 1, 1, 3);
        tbl[18] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 0);
        tbl[19] = mk(1, 2, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 0);
        tbl[20] = mk(1, 9, 1, 16'h00B1, 0, 16'h00B1, 1, 1, 0, 0, 0);
        tbl[21] = mk(0, 0, 1, 16'h00B2, 0, 16'h00B1, 0, 1, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 16'h0000, 1, 16'h00B2, 0, 1, 0, 0, 1);
        tbl[23] = mk(0, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 1, 0, 2);

        rst_n = 1'b1;
        do_reset();
        #1;
        compare("reset", 16'h0000, 0, 0, 0, 0, 0);

        // basic tile, underrun, over-offer, zero-length and ignored mid-tile start
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].start, tbl[i].cfg, tbl[i].iv, tbl[i].data, tbl[i].re, 1'b0);
            compare($sformatf("vec%0d", i), tbl[i].exp_read, tbl[i].exp_ready,
                    tbl[i].exp_busy, tbl[i].exp_done, tbl[i].exp_under, tbl[i].exp_cons);
        end

        // fill to DEPTH with no reads, then streaming pop+push against a queue model
        do_reset();
        step(1, 20, 0, 16'h0000, 0, 0);
        compare("fill.start", 16'h0000, 1, 1, 0, 0, 0);
        begin
            logic [15:0] q[$];
            logic [15:0] nd;
            int          acc;
            int          cons;
            logic        rdy;
            logic        re;
            nd = 16'h0100; acc = 0; cons = 0; rdy = 1'b1;
            for (int c = 0; c < 16; c++) begin
                re = (c >= 10);
                step(0, 0, 1, nd, re, 0);
                if (re && q.size() > 0) begin
                    void'(q.pop_front());
                    cons++;
                end
                if (rdy) begin
                    q.push_back(nd);
                    nd++;
                    acc++;
                end
                rdy = (q.size() < 8) && (acc < 20);
                compare($sformatf("fill%0d", c), (q.size() > 0) ? q[0] : 16'h0000, rdy,
                        1, 0, 0, 32'(cons));
                if (c == 7) check("fill.full_after_8", 32'(bus.in_ready), 32'd0);
            end
        end

        // mid-tile flush with 5 words buffered and underrun already set
        do_reset();
        step(1, 10, 0, 16'h0000, 0, 0);
        step(0, 0, 0, 16'h0000, 1, 0);
        compare("fl.under", 16'h0000, 1, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 16'h0200 + 16'(i), 0, 0);
        compare("fl.buffered", 16'h0200, 1, 1, 0, 1, 0);
        step(0, 0, 0, 16'h0000, 1, 0);
        compare("fl.pop", 16'h0201, 1, 1, 0, 1, 1);
        step(0, 0, 1, 16'h0BAD, 0, 1);
        compare("fl.flush", 16'h0000, 0, 0, 0, 1, 0);
        step(0, 0, 0, 16'h0000, 0, 0);
        compare("fl.idle", 16'h0000, 0, 0, 0, 1, 0);
        step(1, 2, 0, 16'h0000, 0, 0);
        compare("fl.restart", 16'h0000, 1, 1, 0, 0, 0);
        step(0, 0, 1, 16'h0300, 0, 0);
        compare("fl.fresh", 16'h0300, 1, 1, 0, 0, 0);

`ifdef STENCIL_FEEDER_LFSR_EN
        // internal LFSR source: seed 0xACE1 then two shifts
        do_reset();
        lfsr_mode = 1'b1;
        step(1, 3, 0, 16'h0000, 0, 0);
        compare("lfsr.start", 16'h0000, 0, 1, 0, 0, 0);
        step(0, 0, 1, 16'h1234, 0, 0);
        compare("lfsr.w0", 16'hACE1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 16'h1234, 1, 0);
        compare("lfsr.w1", 16'h5670, 0, 1, 0, 0, 1);
        step(0, 0, 0, 16'h0000, 1, 0);
        compare("lfsr.w2", 16'hAB38, 0, 1, 0, 0, 2);
        step(0, 0, 0, 16'h0000, 1, 0);
        compare("lfsr.done", 16'h0000, 0, 0, 1, 0, 3);
        lfsr_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
